// File: rtl/fifo_width_unpacker.sv
// fifo_width_unpacker
//   Width down-converter for the read side of the fifo. It takes one
//   IN_WIDTH word through the fifo's data_out/valid/ack handshake and sends
//   it downstream as RATIO consecutive OUT_WIDTH beats on a valid/ready
//   stream. It holds at most one word. The last beat of each word is flagged
//   with out_last.
//
// Ports
//   clock     : single clock, rising edge
//   rst       : synchronous, active-high reset
//   in_data   : word from the fifo data_out
//   in_valid  : fifo data_out_valid
//   in_ack    : fifo data_out_ack (combinational)
//   out_data  : current beat (muxed from registered state only)
//   out_valid : beat valid
//   out_ready : downstream accepts the beat
//   out_last  : final beat of the current word
//
// Parameter constraints (not checked in hardware): IN_WIDTH must be an
// integer multiple of OUT_WIDTH, and IN_WIDTH/OUT_WIDTH must be >= 2.
//
// States (derived from out_valid)
//   state | meaning
//   EMPTY | no word held; in_ack follows !rst
//   BUSY  | word held; beat beat_cnt is on out_data
module fifo_width_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ack,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  // Number of bits needed to hold value; never less than 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_WIDTH = clogb2(RATIO - 1);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(RATIO - 1);

  logic [IN_WIDTH-1:0]  word_reg;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 at_last;
  logic                 beat_xfer;
  logic                 word_xfer;

  assign at_last   = (beat_cnt == LAST_BEAT);
  assign beat_xfer = out_valid && out_ready;

  // Accept a new word when empty, or in the same cycle the final beat leaves,
  // so back-to-back words stream without a bubble.
  assign in_ack    = !rst && (!out_valid || (out_ready && at_last));
  assign word_xfer = in_valid && in_ack;

  assign out_last  = out_valid && at_last;

  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid <= 1'b0;
      beat_cnt  <= '0;
      word_reg  <= '0;
    end else if (word_xfer) begin
      word_reg  <= in_data;
      beat_cnt  <= '0;
      out_valid <= 1'b1;
    end else if (beat_xfer) begin
      if (at_last) begin
        out_valid <= 1'b0;
        beat_cnt  <= '0;
      end else begin
        beat_cnt  <= beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Slice select driven only by word_reg and beat_cnt; no path from in_data.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (beat_cnt == CNT_WIDTH'(i)) begin
        out_data = word_reg[((LSB_FIRST != 1'b0) ? i : (RATIO - 1 - i)) * OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

endmodule
